// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide, with single-cycle handling of divide-by-zero and signed overflow.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [1:0]      dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [5:0]      LAST_ITER = 6'(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

   logic [1:0]      state;
   logic [5:0]      cnt;
   logic [2:0]      op;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] addend;
   logic            neg_main;
   logic            neg_rem;

   // Operand decode for a request presented in IDLE
   logic            a_signed;
   logic            b_signed;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] special_res;

   always_comb begin
      a_signed    = (funct3_i != 3'b011) && !(funct3_i[2] && funct3_i[0]);
      b_signed    = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
      a_neg       = a_signed && rs1_i[XLEN-1];
      b_neg       = b_signed && rs2_i[XLEN-1];
      mag_a       = a_neg ? (~rs1_i + 1'b1) : rs1_i;
      mag_b       = b_neg ? (~rs2_i + 1'b1) : rs2_i;
      div_zero    = funct3_i[2] && (rs2_i == '0);
      div_ovf     = funct3_i[2] && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES);
      special_res = '0;
      if (div_zero) begin
         special_res = funct3_i[1] ? rs1_i : ALL_ONES;
      end else if (div_ovf) begin
         special_res = funct3_i[1] ? '0 : MIN_NEG;
      end
   end

   // One iteration step; lo is multiplier/quotient, hi is product-high/remainder
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic              div_ok;
   logic [XLEN-1:0]   div_sub;

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
      div_shift = {hi, lo[XLEN-1]};
      div_ok    = (div_shift >= {1'b0, addend});
      div_sub   = div_shift[XLEN-1:0] - addend;
   end

   // Sign correction and result selection at the end of CALC
   logic [2*XLEN-1:0] product;
   logic [2*XLEN-1:0] product_s;
   logic [XLEN-1:0]   quot_s;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   final_res;

   always_comb begin
      product   = {hi, lo};
      product_s = neg_main ? (~product + 1'b1) : product;
      quot_s    = neg_main ? (~lo + 1'b1) : lo;
      rem_s     = neg_rem ? (~hi + 1'b1) : hi;
      final_res = '0;
      if (op[2]) begin
         final_res = op[1] ? rem_s : quot_s;
      end else if (op[1:0] == 2'b00) begin
         final_res = product_s[XLEN-1:0];
      end else begin
         final_res = product_s[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         op       <= '0;
         hi       <= '0;
         lo       <= '0;
         addend   <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         result_o <= '0;
      end else if (flush_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  op <= funct3_i;
                  if (div_zero || div_ovf) begin
                     result_o <= special_res;
                     state    <= DONE;
                  end else begin
                     cnt      <= '0;
                     hi       <= '0;
                     lo       <= funct3_i[2] ? mag_a : mag_b;
                     addend   <= funct3_i[2] ? mag_b : mag_a;
                     neg_main <= a_neg ^ b_neg;
                     neg_rem  <= a_neg;
                     state    <= CALC;
                  end
               end
            end
            CALC: begin
               if (cnt == LAST_ITER) begin
                  result_o <= final_res;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + 6'd1;
                  if (op[2]) begin
                     hi <= div_ok ? div_sub : div_shift[XLEN-1:0];
                     lo <= {lo[XLEN-2:0], div_ok};
                  end else begin
                     hi <= mul_sum[XLEN:1];
                     lo <= {mul_sum[0], lo[XLEN-1:1]};
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o    = (state != IDLE);
   assign done_o    = (state == DONE);
   assign dbg_state = state;

endmodule
